// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with selectable registered or
// first-word-fall-through read, programmable almost-full/almost-empty flags,
// an occupancy output, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

    // Refuse to elaborate with a geometry the flags cannot represent.
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_r;
    logic                  wr_ok;
    logic                  rd_ok;

    assign count        = count_r;
    assign empty        = (count_r == '0);
    assign full         = (count_r == DEPTH_C);
    assign almost_full  = (count_r >= AF_C);
    assign almost_empty = (count_r <= AE_C);

    // Accept decisions; a write into a full FIFO is allowed only alongside a read.
    always_comb begin
        rd_ok = rd_en & ~empty;
        wr_ok = wr_en & (~full | rd_en);
    end

    // Pointers, occupancy and sticky error flags; flush overrides any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_r   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage array; contents are left untouched by reset and flush.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented combinationally; zero while empty.
        assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
        // Registered read: data appears the cycle after an accepted read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout <= '0;
            end else if (flush) begin
                dout <= '0;
            end else if (rd_ok) begin
                dout <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives a registered-read and a FWFT instance with the
// same stimulus and compares both against a queue-based reference model.
module tb_sync_fifo_flex;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AF = 14;
    localparam int AE = 2;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic          full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [CW-1:0] count_a, count_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_dreg;

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
        .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
        .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(unf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dreg = '0;
    endfunction

    // One clock edge of FIFO behaviour, from the pre-edge state.
    function automatic void model_step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
        bit rok, wok;
        if (f) begin
            model_reset();
            return;
        end
        rok = r && (mq.size() > 0);
        wok = w && ((mq.size() < DP) || r);
        if (w && !wok) m_ovf = 1'b1;
        if (r && mq.size() == 0) m_unf = 1'b1;
        if (rok) m_dreg = mq.pop_front();
        if (wok) mq.push_back(d);
    endfunction

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count_reg",   32'(count_a), 32'(n));
        chk("count_fwft",  32'(count_b), 32'(n));
        chk("empty_reg",   32'(empty_a), 32'(n == 0));
        chk("empty_fwft",  32'(empty_b), 32'(n == 0));
        chk("full_reg",    32'(full_a),  32'(n == DP));
        chk("full_fwft",   32'(full_b),  32'(n == DP));
        chk("afull_reg",   32'(af_a),    32'(n >= AF));
        chk("afull_fwft",  32'(af_b),    32'(n >= AF));
        chk("aempty_reg",  32'(ae_a),    32'(n <= AE));
        chk("aempty_fwft", 32'(ae_b),    32'(n <= AE));
        chk("ovf_reg",     32'(ovf_a),   32'(m_ovf));
        chk("ovf_fwft",    32'(ovf_b),   32'(m_ovf));
        chk("unf_reg",     32'(unf_a),   32'(m_unf));
        chk("unf_fwft",    32'(unf_b),   32'(m_unf));
        chk("dout_reg",    32'(dout_a),  32'(m_dreg));
        chk("dout_fwft",   32'(dout_b),  (n == 0) ? 32'd0 : 32'(mq[0]));
    endtask

    task automatic cycle(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
        wr_en = w;
        rd_en = r;
        flush = f;
        din   = d;
        @(posedge clk);
        model_step(w, r, f, d);
        #1;
        check_all();
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_aempty", 32'(ae_a), 32'd1);

        // Fill with 0x01..0x10
        for (int i = 1; i <= DP; i++) begin
            cycle(1'b1, 1'b0, 1'b0, DW'(i));
            if (i == AF - 1) chk("t1_af_below", 32'(af_a), 32'd0);
            if (i == AF)     chk("t1_af_at",    32'(af_a), 32'd1);
        end
        chk("t1_full", 32'(full_a), 32'd1);
        chk("t1_count", 32'(count_a), 32'd16);
        chk("t1_ovf", 32'(ovf_a), 32'd0);

        // Write into full is dropped; drain in order
        cycle(1'b1, 1'b0, 1'b0, 8'hEE);
        chk("t2_ovf", 32'(ovf_a), 32'd1);
        chk("t2_count", 32'(count_a), 32'd16);
        for (int i = 1; i <= DP; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            chk("t2_order", 32'(dout_a), 32'(i));
        end
        chk("t2_ovf_sticky", 32'(ovf_a), 32'd1);

        // Simultaneous write and read on full
        for (int i = 1; i <= DP; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i));
        cycle(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("t3_dout", 32'(dout_a), 32'h01);
        chk("t3_count", 32'(count_a), 32'd16);
        for (int i = 0; i < DP; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        chk("t3_last", 32'(dout_a), 32'hAA);

        // Underflow on empty, then write+read on empty
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("t4_unf", 32'(unf_a), 32'd1);
        chk("t4_dout_hold", 32'(dout_a), 32'hAA);
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        chk("t4_count", 32'(count_a), 32'd1);
        chk("t4_empty", 32'(empty_a), 32'd0);

        // Fall-through head word
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("t5_fwft_head", 32'(dout_b), 32'h3C);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("t5_fwft_empty", 32'(empty_b), 32'd1);
        chk("t5_fwft_zero", 32'(dout_b), 32'd0);

        // Flush with count=5 and overflow set
        for (int i = 0; i <= DP; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h80 + i));
        for (int i = 0; i < DP - 5; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        chk("t6_count5", 32'(count_a), 32'd5);
        chk("t6_ovf_set", 32'(ovf_a), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 8'h77);
        chk("t6_count0", 32'(count_a), 32'd0);
        chk("t6_empty", 32'(empty_a), 32'd1);
        chk("t6_ovf_clr", 32'(ovf_a), 32'd0);
        chk("t6_dout_clr", 32'(dout_a), 32'd0);

        // Randomised traffic alternating write-heavy and read-heavy phases
        for (int i = 0; i < 800; i++) begin
            int wp;
            wp = ((i / 60) % 2 == 0) ? 75 : 30;
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                  $urandom_range(0, 199) == 0, DW'($urandom));
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
        wr_en = 1'b1;
        din   = 8'h99;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        cycle(1'b1, 1'b0, 1'b0, 8'h42);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("post_rst_read", 32'(dout_a), 32'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
